// File: rtl/phy_lane_scheduler.sv
// phy_lane_scheduler: round-robin arbiter that shares one byte-wide PHY
// transmit lane between four buffered input lanes. Everything is clocked by
// clk_4f; every output is registered.
//
// Ports:
//   clk_4f, reset              clock, synchronous active-high reset
//   inN_tx, valid_in N_tx      per-lane data byte and write strobe (N = 0..3)
//   pause                      downstream stall; freezes pops and the pointer
//   out_data, valid_out        granted byte, or IDLE_BYTE with valid_out=0
//   out_lane                   source lane of out_data when valid_out=1
//   almost_fullN               lane FIFO occupancy >= AF_THRESH
//   overflowN                  sticky flag: a lane write was dropped
module phy_lane_scheduler #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned AF_THRESH  = 3,
   parameter int unsigned INIT_IDLES = 4,
   parameter logic [7:0]  IDLE_BYTE  = 8'hBC
) (
   input  logic       clk_4f,
   input  logic       reset,
   input  logic [7:0] in0_tx,
   input  logic [7:0] in1_tx,
   input  logic [7:0] in2_tx,
   input  logic [7:0] in3_tx,
   input  logic       valid_in0_tx,
   input  logic       valid_in1_tx,
   input  logic       valid_in2_tx,
   input  logic       valid_in3_tx,
   input  logic       pause,
   output logic [7:0] out_data,
   output logic       valid_out,
   output logic [1:0] out_lane,
   output logic       almost_full0,
   output logic       almost_full1,
   output logic       almost_full2,
   output logic       almost_full3,
   output logic       overflow0,
   output logic       overflow1,
   output logic       overflow2,
   output logic       overflow3
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned IDLE_W = $clog2(INIT_IDLES + 1);

   typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_PAUSED} state_t;

   logic [7:0]       din [4];
   logic [3:0]       vin;
   logic [7:0]       mem [4][FIFO_DEPTH];
   logic [PTR_W-1:0] wptr [4];
   logic [PTR_W-1:0] rptr [4];
   logic [CNT_W-1:0] count [4];
   logic [CNT_W-1:0] count_nxt [4];

   state_t           state_q, state_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic [1:0]       last_q, last_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic [1:0]       lane_q, lane_d;
   logic [3:0]       pop, push, af_q, ovf_q;
   logic             grant_hit;
   logic [1:0]       grant, cand;

   assign din[0] = in0_tx;
   assign din[1] = in1_tx;
   assign din[2] = in2_tx;
   assign din[3] = in3_tx;
   assign vin    = {valid_in3_tx, valid_in2_tx, valid_in1_tx, valid_in0_tx};

   assign out_data     = data_q;
   assign valid_out    = valid_q;
   assign out_lane     = lane_q;
   assign almost_full0 = af_q[0];
   assign almost_full1 = af_q[1];
   assign almost_full2 = af_q[2];
   assign almost_full3 = af_q[3];
   assign overflow0    = ovf_q[0];
   assign overflow1    = ovf_q[1];
   assign overflow2    = ovf_q[2];
   assign overflow3    = ovf_q[3];

   // Next-state, arbitration and next-output logic
   always_comb begin
      state_d   = state_q;
      idle_d    = idle_q;
      last_d    = last_q;
      data_d    = IDLE_BYTE;
      valid_d   = 1'b0;
      lane_d    = lane_q;
      pop       = '0;
      grant_hit = 1'b0;
      grant     = last_q;
      cand      = '0;

      // Search last+1 .. last+4 (mod 4); the fourth candidate is last itself
      for (int i = 1; i <= 4; i++) begin
         cand = last_q + 2'(i);
         if (!grant_hit && count[cand] != '0) begin
            grant_hit = 1'b1;
            grant     = cand;
         end
      end

      case (state_q)
         ST_INIT: begin
            idle_d = idle_q + IDLE_W'(1);
            if (idle_q == IDLE_W'(INIT_IDLES - 1))
               state_d = pause ? ST_PAUSED : ST_RUN;
         end
         ST_RUN: begin
            if (pause) begin
               state_d = ST_PAUSED;
            end else if (grant_hit) begin
               pop[grant] = 1'b1;
               data_d     = mem[grant][rptr[grant]];
               valid_d    = 1'b1;
               lane_d     = grant;
               last_d     = grant;
            end
         end
         ST_PAUSED: begin
            if (!pause) state_d = ST_RUN;
         end
         default: state_d = ST_INIT;
      endcase
   end

   // A full lane still accepts a write when it is popped at the same edge
   always_comb begin
      for (int l = 0; l < 4; l++) begin
         push[l]      = vin[l] && ((count[l] < CNT_W'(FIFO_DEPTH)) || pop[l]);
         count_nxt[l] = count[l] + CNT_W'(push[l]) - CNT_W'(pop[l]);
      end
   end

   // State, output and FIFO bookkeeping registers
   always_ff @(posedge clk_4f) begin
      if (reset) begin
         state_q <= ST_INIT;
         idle_q  <= '0;
         last_q  <= 2'd3;
         data_q  <= IDLE_BYTE;
         valid_q <= 1'b0;
         lane_q  <= 2'd0;
         af_q    <= '0;
         ovf_q   <= '0;
         for (int l = 0; l < 4; l++) begin
            wptr[l]  <= '0;
            rptr[l]  <= '0;
            count[l] <= '0;
         end
      end else begin
         state_q <= state_d;
         idle_q  <= idle_d;
         last_q  <= last_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         lane_q  <= lane_d;
         for (int l = 0; l < 4; l++) begin
            if (push[l]) wptr[l] <= wptr[l] + PTR_W'(1);
            if (pop[l])  rptr[l] <= rptr[l] + PTR_W'(1);
            count[l] <= count_nxt[l];
            af_q[l]  <= (count_nxt[l] >= CNT_W'(AF_THRESH));
            if (vin[l] && !push[l]) ovf_q[l] <= 1'b1;
         end
      end
   end

   // FIFO storage needs no reset; contents are dead once pointers clear
   always_ff @(posedge clk_4f) begin
      for (int l = 0; l < 4; l++) begin
         if (!reset && push[l]) mem[l][wptr[l]] <= din[l];
      end
   end

endmodule

// File: tb/tb_phy_lane_scheduler.sv
// tb_phy_lane_scheduler: directed test-plan scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_phy_lane_scheduler;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AF    = 3;
   localparam int unsigned IDLES = 4;
   localparam logic [7:0]  IDLE  = 8'hBC;

   logic       clk_4f = 1'b0;
   logic       reset  = 1'b1;
   logic [7:0] in0_tx = '0, in1_tx = '0, in2_tx = '0, in3_tx = '0;
   logic       valid_in0_tx = 1'b0, valid_in1_tx = 1'b0;
   logic       valid_in2_tx = 1'b0, valid_in3_tx = 1'b0;
   logic       pause = 1'b0;
   logic [7:0] out_data;
   logic       valid_out;
   logic [1:0] out_lane;
   logic       almost_full0, almost_full1, almost_full2, almost_full3;
   logic       overflow0, overflow1, overflow2, overflow3;

   int n_checks = 0;
   int n_fail   = 0;

   phy_lane_scheduler #(
      .FIFO_DEPTH(DEPTH), .AF_THRESH(AF), .INIT_IDLES(IDLES), .IDLE_BYTE(IDLE)
   ) dut (
      .clk_4f(clk_4f), .reset(reset),
      .in0_tx(in0_tx), .in1_tx(in1_tx), .in2_tx(in2_tx), .in3_tx(in3_tx),
      .valid_in0_tx(valid_in0_tx), .valid_in1_tx(valid_in1_tx),
      .valid_in2_tx(valid_in2_tx), .valid_in3_tx(valid_in3_tx),
      .pause(pause), .out_data(out_data), .valid_out(valid_out), .out_lane(out_lane),
      .almost_full0(almost_full0), .almost_full1(almost_full1),
      .almost_full2(almost_full2), .almost_full3(almost_full3),
      .overflow0(overflow0), .overflow1(overflow1),
      .overflow2(overflow2), .overflow3(overflow3)
   );

   always #5 clk_4f = ~clk_4f;

   // Reference model: one byte queue per lane plus a few scalars
   typedef logic [7:0] byte_q_t [$];
   byte_q_t    mq [4];
   int         m_init_left;
   int         m_last;
   bit         m_pause_prev;
   logic [7:0] e_data;
   logic       e_valid;
   logic [1:0] e_lane;
   logic [3:0] e_af, e_ovf;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic p, input logic [3:0] v,
                             input logic [7:0] d0, d1, d2, d3);
      logic [7:0] d [4];
      int g;
      d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
      if (r) begin
         for (int l = 0; l < 4; l++) mq[l].delete();
         m_init_left  = IDLES;
         m_last       = 3;
         m_pause_prev = 1'b0;
         e_data = IDLE; e_valid = 1'b0; e_lane = 2'd0; e_af = '0; e_ovf = '0;
      end else begin
         // Grant only once INIT is over and pause was low at this and the previous edge
         g = -1;
         if (m_init_left == 0 && !p && !m_pause_prev) begin
            for (int k = 1; k <= 4; k++) begin
               int l;
               l = (m_last + k) % 4;
               if (g < 0 && mq[l].size() > 0) g = l;
            end
         end
         if (g >= 0) begin
            e_data  = mq[g].pop_front();
            e_valid = 1'b1;
            e_lane  = 2'(g);
            m_last  = g;
         end else begin
            e_data  = IDLE;
            e_valid = 1'b0;
         end
         for (int l = 0; l < 4; l++) begin
            if (v[l]) begin
               if (mq[l].size() < DEPTH) mq[l].push_back(d[l]);
               else e_ovf[l] = 1'b1;
            end
            e_af[l] = (mq[l].size() >= AF);
         end
         if (m_init_left > 0) m_init_left--;
         m_pause_prev = p;
      end
   endtask

   // Apply inputs, take one edge, update the model, compare all outputs
   task automatic step(input logic r, input logic p, input logic [3:0] v,
                       input logic [7:0] d0, d1, d2, d3);
      reset = r; pause = p;
      {valid_in3_tx, valid_in2_tx, valid_in1_tx, valid_in0_tx} = v;
      in0_tx = d0; in1_tx = d1; in2_tx = d2; in3_tx = d3;
      @(posedge clk_4f);
      model_edge(r, p, v, d0, d1, d2, d3);
      #1;
      chk("valid_out", 32'(valid_out), 32'(e_valid));
      chk("out_data", 32'(out_data), 32'(e_data));
      chk("out_lane", 32'(out_lane), 32'(e_lane));
      chk("almost_full", 32'({almost_full3, almost_full2, almost_full1, almost_full0}), 32'(e_af));
      chk("overflow", 32'({overflow3, overflow2, overflow1, overflow0}), 32'(e_ovf));
   endtask

   task automatic idle_step(input logic p);
      step(1'b0, p, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic rst_seq();
      step(1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      step(1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      chk("rst_data", 32'(out_data), 32'(IDLE));
      chk("rst_valid", 32'(valid_out), 32'd0);
   endtask

   initial begin
      logic [7:0] rr [4];
      logic       rp, rr_rst;
      logic [3:0] rv;
      rr[0] = 8'h00; rr[1] = 8'h0E; rr[2] = 8'h8E; rr[3] = 8'h4E;

      // Reset, INIT and round robin: two bytes per lane written from deassertion
      rst_seq();
      step(1'b0, 1'b0, 4'hF, rr[0], rr[1], rr[2], rr[3]);
      chk("init_valid", 32'(valid_out), 32'd0);
      step(1'b0, 1'b0, 4'hF, rr[0], rr[1], rr[2], rr[3]);
      chk("init_valid", 32'(valid_out), 32'd0);
      idle_step(1'b0);
      chk("init_valid", 32'(valid_out), 32'd0);
      idle_step(1'b0);
      chk("init_valid", 32'(valid_out), 32'd0);
      chk("init_data", 32'(out_data), 32'(IDLE));
      for (int i = 0; i < 8; i++) begin
         idle_step(1'b0);
         chk("rr_valid", 32'(valid_out), 32'd1);
         chk("rr_lane", 32'(out_lane), 32'(i % 4));
         chk("rr_data", 32'(out_data), 32'(rr[i % 4]));
      end
      idle_step(1'b0);
      chk("rr_drained", 32'(valid_out), 32'd0);

      // Sparse fairness: lanes 1 and 3 only
      rst_seq();
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, 4'b1010, 8'h00, 8'($urandom), 8'h00, 8'($urandom));
      idle_step(1'b0);
      for (int i = 0; i < 6; i++) begin
         idle_step(1'b0);
         chk("sparse_valid", 32'(valid_out), 32'd1);
         chk("sparse_lane", 32'(out_lane), (i % 2 == 0) ? 32'd1 : 32'd3);
      end

      // Overflow on lane 2 while paused
      rst_seq();
      for (int i = 0; i < 4; i++) idle_step(1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 4'b0100, 8'h00, 8'h00, 8'(8'hC0 + i), 8'h00);
         if (i == 2) chk("af2_after3", 32'(almost_full2), 32'd1);
         if (i == 3) chk("ovf2_before5", 32'(overflow2), 32'd0);
      end
      chk("ovf2_set", 32'(overflow2), 32'd1);
      idle_step(1'b0);
      chk("unpause_idle", 32'(valid_out), 32'd0);
      for (int i = 0; i < 4; i++) begin
         idle_step(1'b0);
         chk("ovf_data", 32'(out_data), 32'(8'hC0 + i));
         chk("ovf_lane", 32'(out_lane), 32'd2);
      end
      idle_step(1'b0);
      chk("ovf_no_c4", 32'(valid_out), 32'd0);
      chk("ovf2_sticky", 32'(overflow2), 32'd1);

      // Full lane 0 written at the same edge it is granted
      idle_step(1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b0001, 8'(8'h10 + i), 8'h00, 8'h00, 8'h00);
      idle_step(1'b0);
      step(1'b0, 1'b0, 4'b0001, 8'h14, 8'h00, 8'h00, 8'h00);
      chk("fullpop_data", 32'(out_data), 32'h10);
      chk("fullpop_ovf0", 32'(overflow0), 32'd0);
      chk("fullpop_af0", 32'(almost_full0), 32'd1);
      for (int i = 1; i < 5; i++) begin
         idle_step(1'b0);
         chk("fullpop_drain", 32'(out_data), 32'(8'h10 + i));
      end

      // Reset while three lanes hold data
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 4'b0111, 8'hA0, 8'hA1, 8'hA2, 8'h00);
      step(1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
      chk("mr_data", 32'(out_data), 32'(IDLE));
      chk("mr_af", 32'({almost_full2, almost_full1, almost_full0}), 32'd0);
      chk("mr_ovf", 32'(overflow2), 32'd0);
      for (int i = 0; i < 10; i++) begin
         idle_step(1'b0);
         chk("mr_no_stale", 32'(valid_out), 32'd0);
      end

      // Random traffic with sticky pause and rare resets
      rp = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 99) < 8) rp = ~rp;
         rr_rst = ($urandom_range(0, 299) == 0);
         for (int l = 0; l < 4; l++) rv[l] = ($urandom_range(0, 9) < 4);
         step(rr_rst, rp, rv, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
